// File: rtl/rf_scan_controller_if.sv
// Handshake and status bundle between the RF scan controller, the layer FSM and the RF/convolution datapath.
// master = controller side, slave = the surrounding datapath/control that drives start, abort and rf_ready.
interface rf_scan_controller_if;
    logic       start;
    logic       abort;
    logic       rf_ready;
    logic [5:0] rowNumber;
    logic [5:0] column;
    logic       rf_valid;
    logic       busy;
    logic       done;
    logic [6:0] group_count;

    modport master (
        input  start, abort, rf_ready,
        output rowNumber, column, rf_valid, busy, done, group_count
    );

    modport slave (
        output start, abort, rf_ready,
        input  rowNumber, column, rf_valid, busy, done, group_count
    );
endinterface

// File: rtl/rf_scan_controller.sv
// Walks (row, half-column) patch groups over a feature map, offering each to the convolution array.
// Latency: SETTLE cycles per group before rf_valid, all outputs registered; done one cycle after the last accept.
// Backpressure: holds the offered group with stable outputs while rf_ready is low, no timeout.
module rf_scan_controller #(
    parameter int H      = 32,
    parameter int W      = 32,
    parameter int F      = 5,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    rf_scan_controller_if.master bus
);
    localparam logic [5:0] LAST_ROW    = 6'(H - F);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("rf_scan_controller: SETTLE must lie in 1..15");
    end
    if (H - F + 1 < 1 || H - F + 1 > 63 || W < 2) begin : g_bad_geometry
        $error("rf_scan_controller: unsupported H/F/W combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_OFFER,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] row_q,   row_d;
    logic       col_q,   col_d;
    logic [6:0] gcnt_q,  gcnt_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       vld_q,   vld_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        gcnt_d  = gcnt_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        // Abort beats a coincident handshake, so the group in flight is never counted.
        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_IDLE;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d = S_SETTLE;
                        row_d   = 6'd0;
                        col_d   = 1'b0;
                        gcnt_d  = 7'd0;
                        cnt_d   = 4'd0;
                        vld_d   = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
                S_SETTLE: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = S_OFFER;
                        vld_d   = 1'b1;
                    end
                end
                S_OFFER: begin
                    if (vld_q && bus.rf_ready) begin
                        gcnt_d = gcnt_q + 7'd1;
                        vld_d  = 1'b0;
                        cnt_d  = 4'd0;
                        if (!col_q) begin
                            col_d   = 1'b1;
                            state_d = S_SETTLE;
                        end else if (row_q < LAST_ROW) begin
                            col_d   = 1'b0;
                            row_d   = row_q + 6'd1;
                            state_d = S_SETTLE;
                        end else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            row_q   <= 6'd0;
            col_q   <= 1'b0;
            gcnt_q  <= 7'd0;
            cnt_q   <= 4'd0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            gcnt_q  <= gcnt_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.rowNumber   = row_q;
    assign bus.column      = {5'd0, col_q};
    assign bus.rf_valid    = vld_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.group_count = gcnt_q;
endmodule

// File: tb/tb_rf_scan_controller.sv
// Bench for rf_scan_controller: two instances (SETTLE=1 and SETTLE=3) share stimulus and are checked
// every cycle against a group-index/elapsed-cycles model, plus directed literal expectations.
module tb_rf_scan_controller;
    localparam int H  = 32;
    localparam int F  = 5;
    localparam int NG = 2 * (H - F + 1);
    localparam int S0 = 1;
    localparam int S1 = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic rf_ready = 1'b1;

    always #5 clk = ~clk;

    rf_scan_controller_if bus0 ();
    rf_scan_controller_if bus1 ();

    assign bus0.start    = start;
    assign bus0.abort    = abort;
    assign bus0.rf_ready = rf_ready;
    assign bus1.start    = start;
    assign bus1.abort    = abort;
    assign bus1.rf_ready = rf_ready;

    rf_scan_controller #(.H(H), .W(32), .F(F), .SETTLE(S0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    rf_scan_controller #(.H(H), .W(32), .F(F), .SETTLE(S1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int hs_q[$];

    // Model: a scan is a walk over group index 0..NG-1; row = idx/2, column = idx%2.
    bit m_active [2];
    bit m_done   [2];
    int m_idx    [2];
    int m_wait   [2];
    int m_acc    [2];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int settle_of(input int d);
        return (d == 0) ? S0 : S1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_active[d] = 1'b0;
            m_done[d]   = 1'b0;
            m_idx[d]    = 0;
            m_wait[d]   = 0;
            m_acc[d]    = 0;
        end
    endtask

    task automatic model_step(input int d);
        int st;
        st = settle_of(d);
        if (m_done[d]) begin
            m_done[d] = 1'b0;
        end else if (!m_active[d]) begin
            if (start && !abort) begin
                m_active[d] = 1'b1;
                m_idx[d]    = 0;
                m_wait[d]   = 0;
                m_acc[d]    = 0;
            end
        end else if (abort) begin
            m_active[d] = 1'b0;
        end else if (m_wait[d] >= st) begin
            if (rf_ready) begin
                m_acc[d]++;
                if (m_idx[d] == NG - 1) begin
                    m_active[d] = 1'b0;
                    m_done[d]   = 1'b1;
                end else begin
                    m_idx[d]++;
                    m_wait[d] = 0;
                end
            end
        end else begin
            m_wait[d]++;
        end
    endtask

    task automatic compare_one(input int d, input int row, input int col, input int vld,
                               input int bsy, input int dn, input int gc);
        check($sformatf("d%0d_rowNumber", d), row, m_idx[d] / 2);
        check($sformatf("d%0d_column", d), col, m_idx[d] % 2);
        check($sformatf("d%0d_rf_valid", d), vld, (m_active[d] && m_wait[d] >= settle_of(d)) ? 1 : 0);
        check($sformatf("d%0d_busy", d), bsy, m_active[d] ? 1 : 0);
        check($sformatf("d%0d_done", d), dn, m_done[d] ? 1 : 0);
        check($sformatf("d%0d_group_count", d), gc, m_acc[d]);
    endtask

    // One clock: model advances on the edge, outputs compared 1 time unit later, returns at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            cyc++;
            if (bus0.rf_valid && rf_ready)
                hs_q.push_back(int'(bus0.rowNumber) * 2 + int'(bus0.column));
            model_step(0);
            model_step(1);
        end
        #1;
        if (reset) begin
            compare_one(0, int'(bus0.rowNumber), int'(bus0.column), int'(bus0.rf_valid),
                        int'(bus0.busy), int'(bus0.done), int'(bus0.group_count));
            compare_one(1, int'(bus1.rowNumber), int'(bus1.column), int'(bus1.rf_valid),
                        int'(bus1.busy), int'(bus1.done), int'(bus1.group_count));
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int ok;
        ok = 0;
        for (int i = 0; i < 400 && ok == 0; i++) begin
            if (!bus0.busy && !bus1.busy && !bus0.done && !bus1.done) ok = 1;
            else tick();
        end
        check(name, ok, 1);
    endtask

    task automatic wait_group0(input int row, input int col, input string name);
        int ok;
        ok = 0;
        for (int i = 0; i < 300 && ok == 0; i++) begin
            if (bus0.rf_valid && int'(bus0.rowNumber) == row && int'(bus0.column) == col) ok = 1;
            else tick();
        end
        check(name, ok, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_row"},   int'(bus0.rowNumber),   0);
        check({tag, "_col"},   int'(bus0.column),      0);
        check({tag, "_valid"}, int'(bus0.rf_valid),    0);
        check({tag, "_busy"},  int'(bus0.busy),        0);
        check({tag, "_done"},  int'(bus0.done),        0);
        check({tag, "_gc"},    int'(bus0.group_count), 0);
        check({tag, "_busy1"}, int'(bus1.busy),        0);
    endtask

    int c0, done0_cyc, done1_cyc, first_v1, ok;

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // Full scan, rf_ready high.
        hs_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc;
        check("scan_busy_rise", int'(bus0.busy), 1);
        check("scan_valid_low", int'(bus0.rf_valid), 0);
        done0_cyc = -1;
        done1_cyc = -1;
        first_v1  = -1;
        for (int i = 0; i < 400 && done1_cyc < 0; i++) begin
            if (bus0.done && done0_cyc < 0) begin
                done0_cyc = cyc;
                check("scan_gc_at_done", int'(bus0.group_count), 56);
                check("scan_busy_at_done", int'(bus0.busy), 0);
                check("scan_final_row", int'(bus0.rowNumber), 27);
                check("scan_final_col", int'(bus0.column), 1);
            end
            if (bus1.rf_valid && first_v1 < 0) first_v1 = cyc;
            if (bus1.done) done1_cyc = cyc;
            if (done1_cyc < 0) tick();
        end
        check("done0_offset", done0_cyc - c0, 112);
        check("done1_offset", done1_cyc - c0, 224);
        check("settle3_first_valid", first_v1 - c0, 3);
        check("hs_count", hs_q.size(), 56);
        for (int i = 0; i < hs_q.size() && i < 56; i++)
            check($sformatf("hs_order_%0d", i), hs_q[i], i);
        tick();
        check("done_one_cycle", int'(bus0.done), 0);
        wait_idle("scan_idle");

        // Backpressure on (3,1).
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_group0(3, 1, "bp_reach_3_1");
        rf_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", int'(bus0.rf_valid), 1);
            check("bp_row", int'(bus0.rowNumber), 3);
            check("bp_col", int'(bus0.column), 1);
        end
        rf_ready = 1'b1;
        tick();
        wait_group0(4, 0, "bp_next_4_0");
        wait_idle("bp_idle");

        // Abort coincident with the handshake on (10,0).
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_group0(10, 0, "abort_reach_10_0");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", int'(bus0.busy), 0);
        check("abort_valid", int'(bus0.rf_valid), 0);
        check("abort_gc", int'(bus0.group_count), 20);
        check("abort_row", int'(bus0.rowNumber), 10);
        check("abort_col", int'(bus0.column), 0);
        for (int i = 0; i < 3; i++) tick();
        check("abort_no_done", int'(bus0.done), 0);
        wait_idle("abort_idle");
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_row", int'(bus0.rowNumber), 0);
        check("restart_col", int'(bus0.column), 0);
        check("restart_gc", int'(bus0.group_count), 0);
        check("restart_busy", int'(bus0.busy), 1);

        // Asynchronous reset mid-offer on (5,1), released between edges.
        wait_group0(5, 1, "rst_reach_5_1");
        reset = 1'b0;
        start = 1'b1;
        model_reset();
        #1;
        check_all_zero("async_rst");
        #2;
        reset = 1'b1;
        tick();
        start = 1'b0;
        check("post_rst_busy", int'(bus0.busy), 1);
        check("post_rst_row", int'(bus0.rowNumber), 0);
        ok = 0;
        for (int i = 0; i < 200 && ok == 0; i++) begin
            if (bus0.done) ok = 1;
            else tick();
        end
        check("post_rst_done", ok, 1);
        check("post_rst_gc", int'(bus0.group_count), 56);
        wait_idle("post_rst_idle");

        // start held through a whole scan: one scan, then a new one right after DONE.
        start = 1'b1;
        tick();
        ok = 0;
        for (int i = 0; i < 200 && ok == 0; i++) begin
            if (bus0.done) ok = 1;
            else tick();
        end
        check("held_done", ok, 1);
        check("held_gc", int'(bus0.group_count), 56);
        tick();
        check("held_idle_busy", int'(bus0.busy), 0);
        check("held_idle_done", int'(bus0.done), 0);
        tick();
        check("held_rescan_busy", int'(bus0.busy), 1);
        check("held_rescan_row", int'(bus0.rowNumber), 0);
        check("held_rescan_gc", int'(bus0.group_count), 0);
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check("final_busy0", int'(bus0.busy), 0);
        check("final_busy1", int'(bus1.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
